// File: rtl/fd_reg_pkg.sv
// Shared CPU constants and the F/D pipeline bundle type.
// The PC, NPC and CP0 blocks use the same package.
package cpu_defs;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [4:0]  EXC_NONE  = 5'd0;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
    } fd_bundle_t;

    // Link address; wraps modulo 2^32 by design.
    function automatic logic [31:0] pc_plus8(input logic [31:0] pc);
        return pc + 32'd8;
    endfunction

endpackage

// File: rtl/fd_reg.sv
// Fetch-to-decode pipeline register: capture, hold on stall, flush on
// interrupt/exception, and delay-slot tracking for EPC/Cause.BD.
module fd_reg
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter logic [31:0] NOP      = cpu_defs::NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc_f,
    input  logic [4:0]  exc_f,
    input  logic        jump_d,
    input  logic        stall,
    input  logic        intexc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic [4:0]  exc_d,
    output logic        bd_d,
    output logic        valid_d
);

    localparam fd_bundle_t FD_RESET = '{
        instr: NOP,
        pc:    RESET_PC,
        pc8:   RESET_PC + 32'd8,
        exc:   EXC_NONE,
        bd:    1'b0,
        valid: 1'b0
    };

    fd_bundle_t fd_d;
    fd_bundle_t fd_q;

    // Next-state: flush beats stall, stall beats capture.
    always_comb begin
        fd_d = fd_q;
        if (intexc) begin
            // Bubble keeps the current fetch PC so a later interrupt has a valid EPC.
            fd_d.instr = NOP;
            fd_d.pc    = pc_f;
            fd_d.pc8   = pc_plus8(pc_f);
            fd_d.exc   = EXC_NONE;
            fd_d.bd    = 1'b0;
            fd_d.valid = 1'b0;
        end else if (!stall) begin
            fd_d.instr = (exc_f == EXC_NONE) ? instr_f : NOP;
            fd_d.pc    = pc_f;
            fd_d.pc8   = pc_plus8(pc_f);
            fd_d.exc   = exc_f;
            fd_d.bd    = jump_d;
            fd_d.valid = 1'b1;
        end else begin
            fd_d = fd_q;
        end
    end

    // Stage register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fd_q <= FD_RESET;
        end else begin
            fd_q <= fd_d;
        end
    end

    assign instr_d = fd_q.instr;
    assign pc_d    = fd_q.pc;
    assign pc8_d   = fd_q.pc8;
    assign exc_d   = fd_q.exc;
    assign bd_d    = fd_q.bd;
    assign valid_d = fd_q.valid;

endmodule

// File: doc/fd_reg.md
# fd_reg

Fetch-to-decode (F/D) pipeline register of the five-stage MIPS core with precise exceptions. It sits directly downstream of the PC/fetch stage. Each cycle it captures the fetched instruction, its PC, and the fetch exception code, and presents them to decode. It also:
- holds its contents on a hazard stall;
- flushes to a bubble when an interrupt or exception redirects fetch;
- records whether the captured instruction occupies a branch delay slot, for EPC/Cause.BD.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value presented after reset.
- NOP, 32'h0000_0000, instruction word used for bubbles and faulted fetches.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- instr_f  input  32  instruction word read from IM at pc_f.
- pc_f  input  32  current fetch PC.
- exc_f  input  5  fetch exception code: 0 = none, 4 = AdEL (misaligned or outside 0x3000–0x4ffc).
- jump_d  input  1  instruction currently in D is a branch/jump, so the instruction being fetched is its delay slot.
- stall  input  1  hazard unit freezes F and D.
- intexc  input  1  interrupt/exception taken this cycle; fetch redirects to 0x0000_4180.
- instr_d  output  32  instruction to decode.
- pc_d  output  32  PC of instr_d.
- pc8_d  output  32  pc_d + 8, link address for jal/jalr/bgezal.
- exc_d  output  5  exception code carried with instr_d.
- bd_d  output  1  instr_d is in a branch delay slot.
- valid_d  output  1  instr_d came from a real fetch (0 = bubble).

## Operation
- Update priority on each rising edge: reset > intexc > stall > capture.
- Reset (asynchronous, takes effect immediately while reset = 0):
  - instr_d = NOP, pc_d = RESET_PC, pc8_d = RESET_PC + 8;
  - exc_d = 0, bd_d = 0, valid_d = 0.
- Flush (intexc = 1), regardless of stall:
  - instr_d = NOP, exc_d = 0, bd_d = 0, valid_d = 0;
  - pc_d = pc_f, pc8_d = pc_f + 8. This keeps a meaningful PC for a bubble later hit by an interrupt.
- Stall (stall = 1, intexc = 0): every output register holds its value.
- Capture (stall = 0, intexc = 0):
  - pc_d = pc_f, pc8_d = pc_f + 8, bd_d = jump_d, valid_d = 1, exc_d = exc_f;
  - instr_d = instr_f if exc_f == 0, else NOP. A faulted fetch never decodes as a real instruction, but its exception code and PC reach the exception unit.
- pc8_d uses 32-bit unsigned add and wraps modulo 2^32. No saturation.
- bd_d samples jump_d in the same cycle as the capture. A stall leaves bd_d consistent with the held instruction.
- No internal state beyond the output registers. This is a pure register stage with control priority.

## Timing
- Latency: 1 cycle from F inputs to D outputs.
- All outputs are registered, with no combinational input-to-output path.
- intexc and stall are sampled at the rising edge only.
- The first handler instruction, fetched at 0x4180 in the cycle after intexc, appears on instr_d two edges after intexc.
- Reset asserted mid-operation clears outputs asynchronously. Deassertion is synchronised externally; the first capture occurs on the first edge with reset = 1.
- Simultaneous stall and intexc: flush applies and the stall is ignored for this stage.

## Structure
- Shared package cpu_defs holds:
  - RESET_PC = 32'h0000_3000;
  - EXC_ENTRY = 32'h0000_4180;
  - NOP = 32'h0;
  - EXC_NONE = 5'd0, EXC_ADEL = 5'd4.
- PC, NPC and CP0 use the same package.
- No sub-module is warranted. All fields share one always block with common priority logic.

## Test plan
- Reset: drive reset = 0 mid-cycle with arbitrary inputs -> outputs immediately show NOP, 0x3000, 0x3008, 0, 0, 0, with no clock needed.
- Capture: instr_f = 0x3c011234, pc_f = 0x3004, exc_f = 0, jump_d = 0 -> after one edge: instr_d = 0x3c011234, pc_d = 0x3004, pc8_d = 0x300c, valid_d = 1, bd_d = 0.
- Stall: hold stall = 1 for 3 edges while pc_f/instr_f change -> all outputs unchanged. Release stall -> new values captured on the next edge.
- Delay slot plus flush priority:
  - capture with jump_d = 1, pc_f = 0x3010 -> bd_d = 1;
  - then stall = 1 and intexc = 1 together -> instr_d = NOP, valid_d = 0, bd_d = 0, pc_d = current pc_f.
- Faulted fetch: pc_f = 0x3002, exc_f = 4, instr_f = 0xffffffff -> instr_d = 0, exc_d = 4, pc_d = 0x3002, valid_d = 1.
- Wrap-around: pc_f = 0xfffffffc (exc_f = 4) -> pc8_d = 0x00000004.
